// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution, control pass-through and an optional
// iterative multiply/divide unit built only when EX_MULDIV_EN is defined.
module ex_stage #(
   parameter int WIDTH = 16,
   parameter int ITER  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] ex_PC_i,
   input  logic [WIDTH-1:0] ex_data1_i,
   input  logic [WIDTH-1:0] ex_data2_i,
   input  logic [2:0]       ex_reg3_i,
   input  logic [15:0]      ex_inst_i,
   input  logic             ex_jump_i,
   input  logic             ex_immOrReg_i,
   input  logic             ex_branch_i,
   input  logic             ex_resultOrMem_i,
   input  logic             ex_memRead_i,
   input  logic             ex_memWrite_i,
   input  logic             ex_regWrite_i,
   input  logic [5:0]       stall_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] memData_o,
   output logic [2:0]       reg3_o,
   output logic             regWrite_o,
   output logic             resultOrMem_o,
   output logic             memRead_o,
   output logic             memWrite_o,
   output logic             branchTaken_o,
   output logic [WIDTH-1:0] branchTarget_o,
   output logic             stallreq_o
);
   // state | meaning
   // IDLE  | nothing in flight; launches when opcode 9/A/B is in EX
   // BUSY  | one shift-add or restoring-divide step per cycle
   // DONE  | result drives result_o until EX is released by stall_i[3]

   localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                          OP_XOR  = 4'h4, OP_SLL = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
                          OP_SLT  = 4'h8, OP_MUL = 4'h9, OP_DIVU = 4'hA, OP_REMU = 4'hB;

   logic [3:0]       opcode;
   logic [WIDTH-1:0] imm_sext, op_a, op_b, alu_res;
   logic             is_md, br_hit, md_stall, md_out_sel;
   logic [WIDTH-1:0] md_out;

   assign opcode   = ex_inst_i[15:12];
   assign imm_sext = {{(WIDTH-6){ex_inst_i[5]}}, ex_inst_i[5:0]};
   assign op_a     = ex_data1_i;
   assign op_b     = ex_immOrReg_i ? imm_sext : ex_data2_i;
   assign is_md    = (opcode == OP_MUL) || (opcode == OP_DIVU) || (opcode == OP_REMU);

   always_comb begin
      alu_res = '0;
      case (opcode)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = op_a << op_b[3:0];
         OP_SRL:  alu_res = op_a >> op_b[3:0];
         OP_SRA:  alu_res = $signed(op_a) >>> op_b[3:0];
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_MUL, OP_DIVU, OP_REMU: alu_res = '0;
         default: alu_res = op_a + op_b;
      endcase
   end

   // Branch compare always uses the register operand, never the immediate.
   assign br_hit        = ex_branch_i && (op_a == ex_data2_i);
   assign branchTaken_o = (ex_jump_i || br_hit) && !md_stall;

   always_comb begin
      branchTarget_o = '0;
      if (ex_jump_i)
         branchTarget_o = {ex_PC_i[WIDTH-1:12], ex_inst_i[11:0]};
      else if (ex_branch_i)
         branchTarget_o = ex_PC_i + imm_sext + WIDTH'(1);
   end

   assign result_o      = md_out_sel ? md_out : alu_res;
   assign memData_o     = ex_data2_i;
   assign reg3_o        = ex_reg3_i;
   assign regWrite_o    = ex_regWrite_i;
   assign resultOrMem_o = ex_resultOrMem_i;
   assign memRead_o     = ex_memRead_i;
   assign memWrite_o    = ex_memWrite_i;
   assign stallreq_o    = md_stall;

`ifdef EX_MULDIV_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} md_state_t;
   localparam int CNT_W = $clog2(ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       md_op;
   logic [WIDTH-1:0] md_a, md_b, md_q, md_acc, md_res;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] mul_sum, div_rem_nxt, div_q_nxt;
   logic             div_fit;
   logic [4:0]       unused_stall;

   // md_q is the multiplier (shifting right) for MUL, dividend/quotient for divide.
   always_comb begin
      mul_sum     = md_acc + (md_q[0] ? md_a : '0);
      div_trial   = {md_acc, md_q[WIDTH-1]};
      div_fit     = (div_trial >= {1'b0, md_b});
      div_rem_nxt = div_fit ? WIDTH'(div_trial - {1'b0, md_b}) : div_trial[WIDTH-1:0];
      div_q_nxt   = {md_q[WIDTH-2:0], div_fit};
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= S_IDLE;
         cnt    <= '0;
         md_op  <= OP_ADD;
         md_a   <= '0;
         md_b   <= '0;
         md_q   <= '0;
         md_acc <= '0;
         md_res <= '0;
      end else if (flush_i) begin
         state  <= S_IDLE;
         cnt    <= '0;
         md_res <= '0;
      end else begin
         case (state)
            S_IDLE: if (is_md) begin
               state  <= S_BUSY;
               cnt    <= '0;
               md_op  <= opcode;
               md_a   <= op_a;
               md_b   <= op_b;
               md_q   <= (opcode == OP_MUL) ? op_b : op_a;
               md_acc <= '0;
            end
            S_BUSY: begin
               cnt <= cnt + CNT_W'(1);
               if (md_op == OP_MUL) begin
                  md_acc <= mul_sum;
                  md_a   <= md_a << 1;
                  md_q   <= md_q >> 1;
               end else begin
                  md_acc <= div_rem_nxt;
                  md_q   <= div_q_nxt;
               end
               if (cnt == CNT_LAST) begin
                  state  <= S_DONE;
                  md_res <= (md_op == OP_MUL)  ? mul_sum :
                            (md_op == OP_DIVU) ? div_q_nxt : div_rem_nxt;
               end
            end
            S_DONE: if (!stall_i[3]) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign md_stall     = (state == S_BUSY) || ((state == S_IDLE) && is_md);
   assign md_out_sel   = (state == S_DONE);
   assign md_out       = md_res;
   assign unused_stall = {stall_i[5:4], stall_i[2:0]};
`else
   logic unused_md;
   assign md_stall   = 1'b0;
   assign md_out_sel = 1'b0;
   assign md_out     = '0;
   assign unused_md  = ^{clk_i, rst_i, flush_i, stall_i, is_md, 32'(ITER)};
`endif

endmodule
